// File: rtl/register_bus_pkg.sv
// Shared types for the register bus initiator: command opcodes, sequencer states
// and the index-width helper used to size register select fields.
package register_bus_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_MOVE  = 2'b01,
    OP_LOADI = 2'b10,
    OP_READ  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RSP  = 2'b11
  } state_e;

  // Select fields stay at least one bit wide even for a single register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/register_bus_decoder.sv
// Index-to-one-hot strobe decoder; the vector is all zeros when en_i is low.
module register_bus_decoder
  import register_bus_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = idx_width(NUM_REGS)
) (
  input  logic [IDX_W-1:0]    idx_i,
  input  logic                en_i,
  output logic [NUM_REGS-1:0] onehot_o
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      assign onehot_o[gi] = en_i && (idx_i == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/register_bus_master.sv
// Sole initiator of the shared register bus: sequences MOVE/LOADI/READ commands
// into one-hot read/save strobes, with every bus-facing output taken from registered state.
module register_bus_master
  import register_bus_pkg::*;
#(
  parameter int    UUID      = 0,
  parameter string NAME      = "",
  parameter int    NUM_REGS  = 8,
  parameter int    BIT_WIDTH = 8,
  parameter int    IDX_W     = idx_width(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [IDX_W-1:0]     cmd_src,
  input  logic [IDX_W-1:0]     cmd_dst,
  input  logic [BIT_WIDTH-1:0] cmd_imm,
  output logic [NUM_REGS-1:0]  rd_en,
  output logic [NUM_REGS-1:0]  wr_en,
  input  logic [BIT_WIDTH-1:0] bus_in,
  output logic [BIT_WIDTH-1:0] bus_out,
  output logic                 bus_drive,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BIT_WIDTH-1:0] rsp_data,
  output logic                 err
);

  if (NUM_REGS < 2 || NUM_REGS > 16 || UUID < 0) begin : g_bad_cfg
    $error("register_bus_master %s: unsupported NUM_REGS %0d", NAME, NUM_REGS);
  end

  state_e                 state_q, state_d;
  op_e                    op_q;
  logic [IDX_W-1:0]       src_q, dst_q;
  logic [BIT_WIDTH-1:0]   hold_q;
  logic                   err_q;
  logic                   accept;
  logic                   idx_bad;
  logic                   rd_sel, wr_sel;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  // Only the indices an opcode actually uses can cause a rejection.
  always_comb begin
    idx_bad = 1'b0;
    case (op_e'(cmd_op))
      OP_MOVE:  idx_bad = !in_range(cmd_src) || !in_range(cmd_dst);
      OP_LOADI: idx_bad = !in_range(cmd_dst);
      OP_READ:  idx_bad = !in_range(cmd_src);
      default:  idx_bad = 1'b0;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && !idx_bad) begin
          case (op_e'(cmd_op))
            OP_MOVE, OP_READ: state_d = ST_RD;
            OP_LOADI:         state_d = ST_WR;
            default:          state_d = ST_IDLE;
          endcase
        end
      end
      ST_RD:   state_d = (op_q == OP_READ) ? ST_RSP : ST_WR;
      ST_WR:   state_d = ST_IDLE;
      ST_RSP:  state_d = rsp_ready ? ST_IDLE : ST_RSP;
      default: state_d = ST_IDLE;
    endcase
  end

  // Command fields are latched only for commands that will actually run.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= OP_NOP;
      src_q  <= '0;
      dst_q  <= '0;
      hold_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept && idx_bad;
      if (accept && !idx_bad) begin
        op_q  <= op_e'(cmd_op);
        src_q <= cmd_src;
        dst_q <= cmd_dst;
        if (op_e'(cmd_op) == OP_LOADI) begin
          hold_q <= cmd_imm;
        end
      end else if (state_q == ST_RD) begin
        hold_q <= bus_in;
      end
    end
  end

  always_comb begin
    rd_sel    = 1'b0;
    wr_sel    = 1'b0;
    bus_drive = 1'b0;
    bus_out   = '0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    case (state_q)
      ST_RD: rd_sel = 1'b1;
      ST_WR: begin
        wr_sel    = 1'b1;
        bus_drive = 1'b1;
        bus_out   = hold_q;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        rsp_data  = hold_q;
      end
      default: ;
    endcase
  end

  assign err = err_q;

  register_bus_decoder #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_rd_dec (
    .idx_i    (src_q),
    .en_i     (rd_sel),
    .onehot_o (rd_en)
  );

  register_bus_decoder #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_wr_dec (
    .idx_i    (dst_q),
    .en_i     (wr_sel),
    .onehot_o (wr_en)
  );

endmodule

// File: tb/tb_register_bus_master.sv
// Randomized bench for register_bus_master: a per-command output timeline model
// plus an attached register file, with directed cases and an out-of-range instance.
module tb_register_bus_master;

  localparam int NR = 8;
  localparam logic [1:0] C_NOP = 2'd0, C_MOVE = 2'd1, C_LOADI = 2'd2, C_READ = 2'd3;

  typedef struct packed {
    logic [7:0] rd;
    logic [7:0] wr;
    logic       drv;
    logic [7:0] out;
    logic       rv;
    logic [7:0] rdata;
    logic       e;
    logic       rdy;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid, cmd_ready, bus_drive, rsp_valid, rsp_ready, err;
  logic [1:0] cmd_op;
  logic [2:0] cmd_src, cmd_dst;
  logic [7:0] cmd_imm, rd_en, wr_en, bus_in, bus_out, rsp_data;

  logic       cmd_valid6, cmd_ready6, bus_drive6, rsp_valid6, rsp_ready6, err6;
  logic [1:0] cmd_op6;
  logic [2:0] cmd_src6, cmd_dst6;
  logic [7:0] cmd_imm6, bus_in6, bus_out6, rsp_data6;
  logic [5:0] rd_en6, wr_en6;

  always #5 clk = ~clk;

  register_bus_master u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm), .rd_en(rd_en), .wr_en(wr_en),
    .bus_in(bus_in), .bus_out(bus_out), .bus_drive(bus_drive), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .err(err)
  );

  register_bus_master #(.NUM_REGS(6)) u_dut6 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid6), .cmd_ready(cmd_ready6), .cmd_op(cmd_op6),
    .cmd_src(cmd_src6), .cmd_dst(cmd_dst6), .cmd_imm(cmd_imm6), .rd_en(rd_en6), .wr_en(wr_en6),
    .bus_in(bus_in6), .bus_out(bus_out6), .bus_drive(bus_drive6), .rsp_valid(rsp_valid6),
    .rsp_ready(rsp_ready6), .rsp_data(rsp_data6), .err(err6)
  );

  int         n_total = 0;
  int         n_pass  = 0;
  bit         started = 1'b0;
  bit         rst_frame = 1'b0;
  bit         rf_init = 1'b1;
  frame_t     exp_q[$];
  frame_t     obs[8];
  frame_t     cmp_e;
  logic [7:0] regs[NR];
  logic [7:0] mem[NR];
  logic [7:0] rd_val;
  logic       s_err6[2], s_rdy6[2];
  logic [5:0] s_rd6[2], s_wr6[2];
  logic [7:0] s_out6[2];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic frame_t mk(input logic [7:0] rd, input logic [7:0] wr, input logic drv,
                                input logic [7:0] out, input logic rv, input logic [7:0] rdata,
                                input logic e, input logic rdy);
    frame_t f;
    f.rd = rd; f.wr = wr; f.drv = drv; f.out = out;
    f.rv = rv; f.rdata = rdata; f.e = e; f.rdy = rdy;
    return f;
  endfunction

  function automatic logic [7:0] oh(input logic [2:0] i);
    return 8'd1 << i;
  endfunction

  // Attached register file and resolved bus
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NR; i++) if (rd_en[i]) rd_val = rd_val | regs[i];
  end
  assign bus_in  = bus_drive ? bus_out : rd_val;
  assign bus_in6 = bus_drive6 ? bus_out6 : 8'h77;

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (rf_init) regs[i] <= 8'(8'h11 * i);
      else if (wr_en[i]) regs[i] <= bus_in;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      rst_frame = 1'b1;
      started   = 1'b1;
    end else begin
      rst_frame = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      if (rst_frame) cmp_e = mk('0, '0, 1'b0, '0, 1'b0, '0, 1'b0, !rst);
      else if (exp_q.size() != 0) cmp_e = exp_q.pop_front();
      else cmp_e = mk('0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      chk("rd_en",     32'(rd_en),     32'(cmp_e.rd));
      chk("wr_en",     32'(wr_en),     32'(cmp_e.wr));
      chk("bus_drive", 32'(bus_drive), 32'(cmp_e.drv));
      chk("bus_out",   32'(bus_out),   32'(cmp_e.out));
      chk("rsp_valid", 32'(rsp_valid), 32'(cmp_e.rv));
      chk("rsp_data",  32'(rsp_data),  32'(cmp_e.rdata));
      chk("err",       32'(err),       32'(cmp_e.e));
      chk("cmd_ready", 32'(cmd_ready), 32'(cmp_e.rdy));
    end
  end

  // Issue one command while idle; k is the number of rsp_ready stall cycles for READ.
  task automatic do_cmd(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d,
                        input logic [7:0] imm, input int k);
    int n;
    cmd_op = op; cmd_src = s; cmd_dst = d; cmd_imm = imm; cmd_valid = 1'b1;
    @(posedge clk);
    n = 0;
    case (op)
      C_MOVE: begin
        exp_q.push_back(mk(oh(s), '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0));
        exp_q.push_back(mk('0, oh(d), 1'b1, mem[s], 1'b0, '0, 1'b0, 1'b0));
        mem[d] = mem[s];
        n = 2;
      end
      C_LOADI: begin
        exp_q.push_back(mk('0, oh(d), 1'b1, imm, 1'b0, '0, 1'b0, 1'b0));
        mem[d] = imm;
        n = 1;
      end
      C_READ: begin
        exp_q.push_back(mk(oh(s), '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0));
        for (int i = 0; i <= k; i++) exp_q.push_back(mk('0, '0, 1'b0, '0, 1'b1, mem[s], 1'b0, 1'b0));
        n = k + 2;
      end
      default: n = 0;
    endcase
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_src = 3'($urandom); cmd_dst = 3'($urandom); cmd_imm = 8'($urandom);
    for (int f = 0; f < n; f++) begin
      if (op == C_READ && f == k + 1) rsp_ready = 1'b1;
      else if (f == 0) rsp_ready = 1'($urandom);
      else rsp_ready = 1'b0;
      @(negedge clk);
      obs[f] = mk(rd_en, wr_en, bus_drive, bus_out, rsp_valid, rsp_data, err, cmd_ready);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b0;
    if (op == C_MOVE || op == C_LOADI) chk("regfile_dst", 32'(regs[d]), 32'(mem[d]));
  endtask

  task automatic idle(input int c);
    cmd_valid = 1'b0;
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do6(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d);
    cmd_op6 = op; cmd_src6 = s; cmd_dst6 = d; cmd_imm6 = 8'h3E; cmd_valid6 = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid6 = 1'b0;
    for (int f = 0; f < 2; f++) begin
      @(negedge clk);
      s_err6[f] = err6; s_rdy6[f] = cmd_ready6; s_rd6[f] = rd_en6; s_wr6[f] = wr_en6; s_out6[f] = bus_out6;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    cmd_valid = 1'b0; cmd_op = '0; cmd_src = '0; cmd_dst = '0; cmd_imm = '0; rsp_ready = 1'b0;
    cmd_valid6 = 1'b0; cmd_op6 = '0; cmd_src6 = '0; cmd_dst6 = '0; cmd_imm6 = '0; rsp_ready6 = 1'b1;
    for (int i = 0; i < NR; i++) mem[i] = 8'(8'h11 * i);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rf_init = 1'b0;

    @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_enables", 32'({rd_en, wr_en, bus_drive}), 32'd0);
    @(posedge clk);
    #1;

    do_cmd(C_LOADI, 3'd0, 3'd3, 8'hA5, 0);
    chk("loadi_wr_en", 32'(obs[0].wr), 32'h08);
    chk("loadi_bus_out", 32'(obs[0].out), 32'hA5);
    chk("loadi_drive", 32'(obs[0].drv), 32'd1);

    do_cmd(C_MOVE, 3'd3, 3'd6, 8'h00, 0);
    chk("move_rd_en", 32'(obs[0].rd), 32'h08);
    chk("move_rd_nodrive", 32'(obs[0].drv), 32'd0);
    chk("move_wr_en", 32'(obs[1].wr), 32'h40);
    chk("move_bus_out", 32'(obs[1].out), 32'hA5);
    chk("move_wr_nord", 32'(obs[1].rd), 32'd0);
    chk("move_reg6", 32'(regs[6]), 32'hA5);

    do_cmd(C_LOADI, 3'd0, 3'd6, 8'h3C, 0);
    do_cmd(C_READ, 3'd6, 3'd0, 8'h00, 4);
    chk("read_rd_en", 32'(obs[0].rd), 32'h40);
    for (int f = 1; f <= 5; f++) begin
      chk("read_rsp_valid", 32'(obs[f].rv), 32'd1);
      chk("read_rsp_data", 32'(obs[f].rdata), 32'h3C);
      chk("read_cmd_ready", 32'(obs[f].rdy), 32'd0);
    end

    do_cmd(C_LOADI, 3'd0, 3'd2, 8'h5A, 0);
    do_cmd(C_MOVE, 3'd2, 3'd2, 8'h00, 0);
    do_cmd(C_NOP, 3'd4, 3'd5, 8'hFF, 0);
    chk("self_move_reg2", 32'(regs[2]), 32'h5A);
    do_cmd(C_LOADI, 3'd0, 3'd5, 8'h11, 0);
    chk("after_nop_wr_en", 32'(obs[0].wr), 32'h20);

    // Reset during the RD cycle of a MOVE 1 -> 7
    cmd_op = C_MOVE; cmd_src = 3'd1; cmd_dst = 3'd7; cmd_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(mk(oh(3'd1), '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0));
    #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_rd_en", 32'(rd_en), 32'h02);
    @(negedge clk);
    chk("rst_enables_off", 32'({rd_en, wr_en, bus_drive}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", 32'(cmd_ready), 32'd1);
    chk("rst_no_write", 32'(regs[7]), 32'h77);
    @(posedge clk);
    #1;

    for (int t = 0; t < 400; t++) begin
      do_cmd(2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 8'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    for (int i = 0; i < NR; i++) chk("final_regfile", 32'(regs[i]), 32'(mem[i]));

    do6(C_MOVE, 3'd7, 3'd1);
    chk("oor_move_err", 32'(s_err6[0]), 32'd1);
    chk("oor_move_rd", 32'(s_rd6[0]), 32'd0);
    chk("oor_move_wr", 32'(s_wr6[0]), 32'd0);
    chk("oor_move_ready", 32'(s_rdy6[0]), 32'd1);
    chk("oor_err_pulse", 32'(s_err6[1]), 32'd0);
    chk("oor_move_quiet", 32'({s_rd6[1], s_wr6[1]}), 32'd0);
    do6(C_LOADI, 3'd0, 3'd6);
    chk("oor_loadi_err", 32'(s_err6[0]), 32'd1);
    chk("oor_loadi_wr", 32'({s_wr6[0], s_wr6[1]}), 32'd0);
    do6(C_MOVE, 3'd5, 3'd0);
    chk("edge_move_err", 32'(s_err6[0]), 32'd0);
    chk("edge_move_rd", 32'(s_rd6[0]), 32'h20);
    chk("edge_move_wr", 32'(s_wr6[1]), 32'h01);
    chk("edge_move_out", 32'(s_out6[1]), 32'h77);
    do6(C_READ, 3'd6, 3'd0);
    chk("oor_read_err", 32'(s_err6[0]), 32'd1);
    chk("oor_read_rd", 32'(s_rd6[0]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
